seq_or_stim_ctrl: RTL and testbench

- Programmable stimulus sequencer that drives the two-thread "or" sequence checker (a/c antecedents, b/d/e compare values, c consequent).
- Plays scripted transactions that exercise the a-thread, the c-thread, or both together.
- Supports repeats with idle gaps and optional consequent suppression.
- Publishes the expected assertion outcome and marks each attempt start, so the bench scoreboard can tag attempts.

---
 rtl/seq_or_stim_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_seq_or_stim_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_or_stim_ctrl.sv
// Stimulus sequencer for the two-thread "or" sequence checker.
// Plays scripted a-thread / c-thread / dual-thread transactions with optional
// repeats, idle gaps and consequent suppression, and publishes the expected
// outcome of each tagged attempt. Every output is registered.
module seq_or_stim_ctrl #(
   parameter int DATA_W  = 32,
   parameter int CNT_W   = 8,
   parameter int GAP_CYC = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic              inject_err,
   input  logic [CNT_W-1:0]  repeat_cnt,
   output logic              a,
   output logic              c,
   output logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] e,
   output logic              attempt_start,
   output logic              busy,
   output logic              done,
   output logic              expect_pass,
   output logic [CNT_W-1:0]  txn_cnt
);

   // Gap counter runs 0 .. GAP_CYC-1; width kept at least one bit.
   localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_GAP,
      ST_DONE
   } state_t;

   // Stimulus bundle in the same order as the output concatenation below.
   typedef struct packed {
      logic              a;
      logic              c;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] d;
      logic [DATA_W-1:0] e;
      logic              att;
   } stim_t;

   state_t           state_reg;
   logic [2:0]       step_reg;
   logic [GAP_W-1:0] gap_reg;
   logic [CNT_W-1:0] rep_reg;   // transactions still to play, including current
   logic [1:0]       mode_reg;
   logic             inj_reg;

   // Output pattern of one RUN step. Suppression only hits the consequent
   // c pulses; the step0 c of the c-thread is an antecedent and always fires.
   function automatic stim_t step_stim(input logic [1:0] m, input logic [2:0] s,
                                       input logic inj);
      stim_t v;
      v     = '0;
      v.att = (s == 3'd0);
      case (m)
         2'd0: begin
            case (s)
               3'd0:    v.a = 1'b1;
               3'd1:    v.b = DATA_W'(1);
               3'd2:    v.e = DATA_W'(1);
               3'd3:    v.c = !inj;
               default: ;
            endcase
         end
         2'd1: begin
            case (s)
               3'd0:    v.c = 1'b1;
               3'd2:    v.d = DATA_W'(2);
               3'd3:    v.e = DATA_W'(2);
               3'd4:    v.c = !inj;
               default: ;
            endcase
         end
         2'd2: begin
            case (s)
               3'd0:    begin v.a = 1'b1; v.c = 1'b1; end
               3'd1:    v.b = DATA_W'(1);
               3'd2:    begin v.d = DATA_W'(2); v.e = DATA_W'(1); end
               3'd3:    begin v.c = !inj; v.e = DATA_W'(2); end
               3'd4:    v.c = !inj;
               default: ;
            endcase
         end
         default: ;
      endcase
      return v;
   endfunction

   // Index of the final step of a transaction for the given mode.
   function automatic logic [2:0] last_step(input logic [1:0] m);
      return (m == 2'd0) ? 3'd3 : 3'd4;
   endfunction

   // Sequencer FSM; outputs are loaded with the values of the state being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= ST_IDLE;
         step_reg      <= '0;
         gap_reg       <= '0;
         rep_reg       <= '0;
         mode_reg      <= '0;
         inj_reg       <= 1'b0;
         a             <= 1'b0;
         c             <= 1'b0;
         b             <= '0;
         d             <= '0;
         e             <= '0;
         attempt_start <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         expect_pass   <= 1'b0;
         txn_cnt       <= '0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start && (mode != 2'd3)) begin
                  mode_reg    <= mode;
                  inj_reg     <= inject_err;
                  rep_reg     <= (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
                  txn_cnt     <= '0;
                  expect_pass <= !inject_err;
                  step_reg    <= 3'd0;
                  busy        <= 1'b1;
                  state_reg   <= ST_RUN;
                  {a, c, b, d, e, attempt_start} <= step_stim(mode, 3'd0, inject_err);
               end
            end
            ST_RUN: begin
               if (step_reg == last_step(mode_reg)) begin
                  if (txn_cnt != '1) txn_cnt <= txn_cnt + CNT_W'(1);
                  rep_reg <= rep_reg - CNT_W'(1);
                  if (rep_reg > CNT_W'(1)) begin
                     if (GAP_CYC > 0) begin
                        state_reg <= ST_GAP;
                        gap_reg   <= '0;
                        {a, c, b, d, e, attempt_start} <= '0;
                     end else begin
                        step_reg <= 3'd0;
                        {a, c, b, d, e, attempt_start} <= step_stim(mode_reg, 3'd0, inj_reg);
                     end
                  end else begin
                     state_reg <= ST_DONE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     {a, c, b, d, e, attempt_start} <= '0;
                  end
               end else begin
                  step_reg <= step_reg + 3'd1;
                  {a, c, b, d, e, attempt_start} <=
                     step_stim(mode_reg, step_reg + 3'd1, inj_reg);
               end
            end
            ST_GAP: begin
               if (gap_reg == GAP_W'(GAP_LAST)) begin
                  state_reg <= ST_RUN;
                  step_reg  <= 3'd0;
                  {a, c, b, d, e, attempt_start} <= step_stim(mode_reg, 3'd0, inj_reg);
               end else begin
                  gap_reg <= gap_reg + GAP_W'(1);
               end
            end
            ST_DONE: begin
               busy      <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_or_stim_ctrl.sv
// Self-checking bench for seq_or_stim_ctrl: directed scenarios plus random
// runs, compared cycle by cycle against a transaction-level expected trace.
module tb_seq_or_stim_ctrl;
   localparam int DATA_W  = 32;
   localparam int CNT_W   = 8;
   localparam int GAP_CYC = 2;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [1:0]        mode = 2'd0;
   logic              inject_err = 1'b0;
   logic [CNT_W-1:0]  repeat_cnt = '0;
   logic              a, c;
   logic [DATA_W-1:0] b, d, e;
   logic              attempt_start, busy, done, expect_pass;
   logic [CNT_W-1:0]  txn_cnt;

   seq_or_stim_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .GAP_CYC(GAP_CYC)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
      .inject_err(inject_err), .repeat_cnt(repeat_cnt),
      .a(a), .c(c), .b(b), .d(d), .e(e),
      .attempt_start(attempt_start), .busy(busy), .done(done),
      .expect_pass(expect_pass), .txn_cnt(txn_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              a;
      logic              c;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] d;
      logic [DATA_W-1:0] e;
      logic              att;
      logic              busy;
      logic              done;
      logic              xp;
      logic [CNT_W-1:0]  txn;
   } rec_t;

   int   checks = 0;
   int   errors = 0;
   rec_t exp_q[$];
   logic last_xp = 1'b0;
   logic [CNT_W-1:0] last_txn = '0;

   function automatic rec_t idle_rec(input logic xp, input logic [CNT_W-1:0] txn);
      rec_t r;
      r     = '0;
      r.xp  = xp;
      r.txn = txn;
      return r;
   endfunction

   // Expected trace of a whole run, one record per cycle after the start edge.
   function automatic void build(input logic [1:0] m, input logic inj,
                                 input logic [CNT_W-1:0] rep);
      int   n, len;
      rec_t r;
      exp_q.delete();
      n   = (rep == 0) ? 1 : int'(rep);
      len = (m == 2'd0) ? 4 : 5;
      for (int t = 0; t < n; t++) begin
         for (int s = 0; s < len; s++) begin
            r      = '0;
            r.busy = 1'b1;
            r.xp   = !inj;
            r.txn  = CNT_W'(t);
            r.att  = (s == 0);
            if (m == 2'd0) begin
               if (s == 0) r.a = 1'b1;
               if (s == 1) r.b = 1;
               if (s == 2) r.e = 1;
               if (s == 3) r.c = !inj;
            end else if (m == 2'd1) begin
               if (s == 0) r.c = 1'b1;
               if (s == 2) r.d = 2;
               if (s == 3) r.e = 2;
               if (s == 4) r.c = !inj;
            end else begin
               if (s == 0) begin r.a = 1'b1; r.c = 1'b1; end
               if (s == 1) r.b = 1;
               if (s == 2) begin r.d = 2; r.e = 1; end
               if (s == 3) begin r.c = !inj; r.e = 2; end
               if (s == 4) r.c = !inj;
            end
            exp_q.push_back(r);
         end
         if (t < n - 1) begin
            for (int g = 0; g < GAP_CYC; g++) begin
               r      = '0;
               r.busy = 1'b1;
               r.xp   = !inj;
               r.txn  = CNT_W'(t + 1);
               exp_q.push_back(r);
            end
         end
      end
      r      = '0;
      r.done = 1'b1;
      r.xp   = !inj;
      r.txn  = CNT_W'(n);
      exp_q.push_back(r);
   endfunction

   task automatic check(input string tag, input rec_t ex);
      rec_t ob;
      ob.a = a; ob.c = c; ob.b = b; ob.d = d; ob.e = e;
      ob.att = attempt_start; ob.busy = busy; ob.done = done;
      ob.xp = expect_pass; ob.txn = txn_cnt;
      checks++;
      assert (ob === ex) else begin
         errors++;
         $error("FAIL %s: got a=%0b c=%0b b=%0h d=%0h e=%0h as=%0b busy=%0b done=%0b xp=%0b txn=%0d, expected a=%0b c=%0b b=%0h d=%0h e=%0h as=%0b busy=%0b done=%0b xp=%0b txn=%0d",
                tag, ob.a, ob.c, ob.b, ob.d, ob.e, ob.att, ob.busy, ob.done, ob.xp, ob.txn,
                ex.a, ex.c, ex.b, ex.d, ex.e, ex.att, ex.busy, ex.done, ex.xp, ex.txn);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Play one run; optionally pulse a stray start somewhere in the middle.
   task automatic run(input logic [1:0] m, input logic inj,
                      input logic [CNT_W-1:0] rep, input bit stray);
      int n, stray_at;
      build(m, inj, rep);
      n        = exp_q.size();
      stray_at = stray ? int'($urandom_range(1, n - 2)) : -1;
      mode = m; inject_err = inj; repeat_cnt = rep; start = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick;
         start = 1'b0;
         check($sformatf("run_m%0d_i%0d_r%0d_cyc%0d", m, inj, rep, i), exp_q[i]);
         if (i == stray_at) begin
            start = 1'b1; mode = m + 2'd1; inject_err = !inj; repeat_cnt = 8'd9;
         end
      end
      tick;
      check($sformatf("idle_after_m%0d", m), idle_rec(!inj, CNT_W'(n == 1 ? 1 : n == 0 ? 0 : int'(rep == 0 ? 1 : rep))));
      last_xp  = !inj;
      last_txn = (rep == 0) ? CNT_W'(1) : rep;
      $display("txn mode=%0d inject_err=%0d repeat=%0d stray_start_at=%0d cycles=%0d",
               m, inj, rep, stray_at, n);
   endtask

   initial begin
      // Reset state
      repeat (3) tick;
      check("reset", idle_rec(1'b0, '0));
      @(negedge clk);
      reset_n = 1'b1;
      tick;
      check("idle_after_reset", idle_rec(1'b0, '0));

      // Directed scenarios
      run(2'd0, 1'b0, 8'd1, 1'b0);
      run(2'd1, 1'b1, 8'd2, 1'b0);
      run(2'd2, 1'b0, 8'd0, 1'b0);

      // Illegal mode start ignored, held values kept
      mode = 2'd3; inject_err = 1'b0; repeat_cnt = 8'd3; start = 1'b1;
      tick;
      start = 1'b0;
      check("mode3_ignored", idle_rec(last_xp, last_txn));
      tick;
      check("mode3_still_idle", idle_rec(last_xp, last_txn));
      $display("txn mode=3 start ignored");

      // Start pulsed during a run is ignored
      run(2'd0, 1'b0, 8'd2, 1'b1);

      // Asynchronous reset at step2 of mode 0
      build(2'd0, 1'b0, 8'd1);
      mode = 2'd0; inject_err = 1'b0; repeat_cnt = 8'd1; start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         start = 1'b0;
         check($sformatf("pre_reset_cyc%0d", i), exp_q[i]);
      end
      #2 reset_n = 1'b0;
      #1 check("async_reset", idle_rec(1'b0, '0));
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         check($sformatf("post_reset_idle%0d", i), idle_rec(1'b0, '0));
      end
      $display("txn mode=0 aborted by reset at step2");
      run(2'd0, 1'b0, 8'd1, 1'b0);

      // Random runs
      for (int k = 0; k < 12; k++) begin
         run(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             CNT_W'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
